// File: rtl/keypad_if.sv
// Keypad scanner bus: row sense in, column drive and key events out.
// The scanner uses the master side; whatever models or reads the keypad uses slave.
interface keypad_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int CW = ($clog2(ROWS * COLS) > 1) ? $clog2(ROWS * COLS) : 1;

  logic [ROWS-1:0] sync_row;
  logic [COLS-1:0] col;
  logic [CW-1:0]   key_code;
  logic            key_valid;
  logic            key_held;
  logic            multi_key;

  modport master (
    input  sync_row,
    output col, key_code, key_valid, key_held, multi_key
  );

  modport slave (
    output sync_row,
    input  col, key_code, key_valid, key_held, multi_key
  );
endinterface

// File: rtl/keypad_scan.sv
// Matrix keypad scanner. While idle, all columns are driven high so any press is
// seen. A press triggers a column walk that locates the key. The key is then
// debounced, reported, and optionally auto-repeated. Finally the scanner waits for
// a debounced all-keys-up before it returns to idle.
module keypad_scan #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DEBOUNCE   = 4,
  parameter int REPEAT_DLY = 0,
  parameter int REPEAT_PER = 8
) (
  input logic      clk_div,
  input logic      rst,
  keypad_if.master kif
);
  localparam int CW  = ($clog2(ROWS * COLS) > 1) ? $clog2(ROWS * COLS) : 1;
  localparam int RW  = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1;
  localparam int CIW = ($clog2(COLS) > 1) ? $clog2(COLS) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SCAN     = 3'd1,
    S_DEBOUNCE = 3'd2,
    S_HELD     = 3'd3,
    S_RELEASE  = 3'd4
  } state_t;

  // Snapshot of the press found during the column walk.
  typedef struct packed {
    logic [ROWS-1:0] pat;
    logic [RW-1:0]   row;
    logic [CIW-1:0]  col;
  } cap_t;

  state_t          state;
  cap_t            cap;
  logic [CIW-1:0]  col_idx;
  logic [7:0]      dcnt;
  logic [15:0]     rcnt;
  logic            rpt_first;
  logic [15:0]     rpt_tgt;
  logic [COLS-1:0] col_q;
  logic [CW-1:0]   key_code_q;
  logic            kv, kh, mk;

  // Index of the lowest set row bit. A capture that reaches debounce has exactly one bit set.
  function automatic logic [RW-1:0] row_of(input logic [ROWS-1:0] v);
    logic [RW-1:0] r;
    r = '0;
    for (int i = ROWS - 1; i >= 0; i--)
      if (v[i]) r = RW'(i);
    return r;
  endfunction

  function automatic logic [COLS-1:0] onehot(input logic [CIW-1:0] idx);
    return COLS'(1) << idx;
  endfunction

  // The first repeat waits REPEAT_DLY held cycles. Each later repeat waits REPEAT_PER cycles.
  assign rpt_tgt = rpt_first ? 16'(REPEAT_DLY - 1) : 16'(REPEAT_PER - 1);

  // Scanner FSM. All outputs are registered, so col always matches the current state.
  always_ff @(posedge clk_div) begin
    if (rst) begin
      state      <= S_IDLE;
      cap        <= '0;
      col_idx    <= '0;
      dcnt       <= '0;
      rcnt       <= '0;
      rpt_first  <= 1'b1;
      col_q      <= '1;
      key_code_q <= '0;
      kv         <= 1'b0;
      kh         <= 1'b0;
      mk         <= 1'b0;
    end else begin
      kv <= 1'b0;
      mk <= 1'b0;
      case (state)
        S_IDLE: begin
          col_q   <= '1;
          kh      <= 1'b0;
          col_idx <= '0;
          dcnt    <= '0;
          rcnt    <= '0;
          if (|kif.sync_row) begin
            state <= S_SCAN;
            col_q <= onehot('0);
          end
        end

        S_SCAN: begin
          if (|kif.sync_row) begin
            cap.pat <= kif.sync_row;
            cap.row <= row_of(kif.sync_row);
            cap.col <= col_idx;
            dcnt    <= '0;
            if ($countones(kif.sync_row) > 1) begin
              // Ghosting-prone chord: refuse it and wait for the keypad to clear.
              mk    <= 1'b1;
              state <= S_RELEASE;
              col_q <= '1;
            end else begin
              state <= S_DEBOUNCE;
            end
          end else if (col_idx == CIW'(COLS - 1)) begin
            state   <= S_IDLE;
            col_idx <= '0;
            col_q   <= '1;
          end else begin
            col_idx <= col_idx + 1'b1;
            col_q   <= onehot(col_idx + 1'b1);
          end
        end

        S_DEBOUNCE: begin
          if (kif.sync_row == cap.pat) begin
            if (dcnt == 8'(DEBOUNCE - 1)) begin
              kv         <= 1'b1;
              kh         <= 1'b1;
              key_code_q <= CW'(int'(cap.row) * COLS + int'(cap.col));
              state      <= S_HELD;
              dcnt       <= '0;
              rcnt       <= '0;
              rpt_first  <= 1'b1;
            end else begin
              dcnt <= dcnt + 1'b1;
            end
          end else begin
            state   <= S_IDLE;
            dcnt    <= '0;
            col_idx <= '0;
            col_q   <= '1;
          end
        end

        S_HELD: begin
          if (!kif.sync_row[cap.row]) begin
            state     <= S_RELEASE;
            kh        <= 1'b0;
            col_q     <= '1;
            dcnt      <= '0;
            rcnt      <= '0;
            rpt_first <= 1'b1;
          end else if (REPEAT_DLY > 0) begin
            if (rcnt == rpt_tgt) begin
              kv        <= 1'b1;
              rcnt      <= '0;
              rpt_first <= 1'b0;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
        end

        S_RELEASE: begin
          col_q <= '1;
          kh    <= 1'b0;
          if (|kif.sync_row) begin
            dcnt <= '0;
          end else if (dcnt == 8'(DEBOUNCE - 1)) begin
            state   <= S_IDLE;
            dcnt    <= '0;
            col_idx <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end

        default: begin
          state     <= S_IDLE;
          col_idx   <= '0;
          dcnt      <= '0;
          rcnt      <= '0;
          rpt_first <= 1'b1;
          col_q     <= '1;
          kh        <= 1'b0;
        end
      endcase
    end
  end

  assign kif.col       = col_q;
  assign kif.key_code  = key_code_q;
  assign kif.key_valid = kv;
  assign kif.key_held  = kh;
  assign kif.multi_key = mk;
endmodule

// File: tb/tb_keypad_scan.sv
// Keypad scanner bench. There are three scanner instances: default, auto-repeat,
// and 2x8. Each one is driven from a planned timeline of key presses. A
// per-cycle expectation trace is derived arithmetically from each press's start
// and release cycles.
module tb_keypad_scan;
  localparam int NCYC = 3000;
  localparam int NK   = 256;

  logic clk_div = 1'b0;
  always #5 clk_div = ~clk_div;

  logic rst0, rst1, rst2;

  keypad_if #(.ROWS(4), .COLS(4)) if0 ();
  keypad_if #(.ROWS(4), .COLS(4)) if1 ();
  keypad_if #(.ROWS(2), .COLS(8)) if2 ();

  keypad_scan #(.ROWS(4), .COLS(4), .DEBOUNCE(4), .REPEAT_DLY(0), .REPEAT_PER(8))
    u0 (.clk_div(clk_div), .rst(rst0), .kif(if0));
  keypad_scan #(.ROWS(4), .COLS(4), .DEBOUNCE(4), .REPEAT_DLY(10), .REPEAT_PER(3))
    u1 (.clk_div(clk_div), .rst(rst1), .kif(if1));
  keypad_scan #(.ROWS(2), .COLS(8), .DEBOUNCE(4), .REPEAT_DLY(0), .REPEAT_PER(8))
    u2 (.clk_div(clk_div), .rst(rst2), .kif(if2));

  int p_rows[3] = '{4, 4, 2};
  int p_cols[3] = '{4, 4, 8};
  int p_d[3]    = '{4, 4, 4};
  int p_dly[3]  = '{0, 10, 0};
  int p_per[3]  = '{8, 3, 8};

  int e_kv[3][NCYC];
  int e_mk[3][NCYC];
  int e_kh[3][NCYC];
  int e_code[3][NCYC];
  int e_col[3][NCYC];
  int code_ev[3][NCYC];

  int kr[3][NK];
  int kc[3][NK];
  int ks[3][NK];
  int ke[3][NK];
  int nk[3];

  int rst_x;
  int n_chk, n_bad, cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  // Record that key (r,c) is down from cycle s up to, but not including, cycle e.
  task automatic add_iv(input int i, input int r, input int c, input int s, input int e);
    if (nk[i] < NK) begin
      kr[i][nk[i]] = r; kc[i][nk[i]] = c; ks[i][nk[i]] = s; ke[i][nk[i]] = e;
      nk[i]++;
    end
  endtask

  // Physical matrix: row r reads high when a key in an energised column of that row is down.
  function automatic int rows_of(input int i, input int m, input int colv);
    int r;
    r = 0;
    for (int k = 0; k < nk[i]; k++)
      if (ks[i][k] <= m && m < ke[i][k] && colv[kc[i][k]])
        r |= (1 << kr[i][k]);
    return r;
  endfunction

  // One key pressed at cycle p while idle, released at cycle rr.
  // The walk reaches column c at p+1+c. The key is accepted after d more matching cycles.
  task automatic single(input int i, input int r, input int c, input int p, input int rr,
                        output int idle, output bit acc);
    int hit, a, d;
    d   = p_d[i];
    hit = p + 1 + c;
    acc = 1'b0;
    if (rr <= hit) begin
      for (int j = 0; j < p_cols[i]; j++) e_col[i][p + 1 + j] = 1 << j;
      idle = p + p_cols[i] + 1;
    end else begin
      for (int j = 0; j <= c; j++) e_col[i][p + 1 + j] = 1 << j;
      for (int cy = hit + 1; cy <= rr; cy++) e_col[i][cy] = 1 << c;
      if (rr <= hit + d) begin
        idle = rr + 1;
      end else begin
        a = hit + d + 1;
        acc = 1'b1;
        e_kv[i][a] = 1;
        code_ev[i][a] = r * p_cols[i] + c;
        for (int cy = a; cy <= rr; cy++) e_kh[i][cy] = 1;
        if (p_dly[i] > 0)
          for (int x = a + p_dly[i]; x <= rr; x += p_per[i]) e_kv[i][x] = 1;
        idle = rr + d + 1;
      end
    end
  endtask

  // Two rows in column c: rejected at the walk hit. Idle follows d zero samples after release.
  task automatic multi(input int i, input int c, input int p, input int rr, output int idle);
    int hit;
    hit = p + 1 + c;
    for (int j = 0; j <= c; j++) e_col[i][p + 1 + j] = 1 << j;
    e_mk[i][hit + 1] = 1;
    idle = rr + p_d[i];
  endtask

  task automatic plan_rand(input int i, input int t0);
    int t, r, c, r2, hold, idle, q, rr, sel, d;
    bit acc, rel;
    d = p_d[i];
    t = t0;
    while (t < NCYC - 200) begin
      sel = $urandom_range(0, 9);
      r   = $urandom_range(0, p_rows[i] - 1);
      c   = $urandom_range(0, p_cols[i] - 1);
      rel = 1'b0;
      if (sel < 6) begin
        hold = $urandom_range(c + d + 2, c + d + 2 + ((p_dly[i] > 0) ? 40 : 12));
        add_iv(i, r, c, t, t + hold);
        single(i, r, c, t, t + hold, idle, acc);
        rel = acc;
      end else if (sel < 8) begin
        hold = $urandom_range(1, c + d + 1);
        add_iv(i, r, c, t, t + hold);
        single(i, r, c, t, t + hold, idle, acc);
      end else begin
        r2   = (r + $urandom_range(1, p_rows[i] - 1)) % p_rows[i];
        hold = $urandom_range(c + 2, c + 10);
        add_iv(i, r, c, t, t + hold);
        add_iv(i, r2, c, t, t + hold);
        multi(i, c, t, t + hold, idle);
        rel = 1'b1;
      end
      // A press landing one cycle before idle restarts the release wait and is never reported.
      if (rel && $urandom_range(0, 3) == 0) begin
        q  = idle - 1;
        r  = $urandom_range(0, p_rows[i] - 1);
        c  = $urandom_range(0, p_cols[i] - 1);
        rr = q + $urandom_range(1, 6);
        add_iv(i, r, c, q, rr);
        idle = rr + d;
      end
      t = idle + $urandom_range(0, 4);
    end
  endtask

  initial begin
    int t, idle, cur;
    bit acc;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    if0.sync_row = '0; if1.sync_row = '0; if2.sync_row = '0;
    n_chk = 0; n_bad = 0; cyc = -1; rst_x = -1;
    for (int i = 0; i < 3; i++) begin
      nk[i] = 0;
      for (int m = 0; m < NCYC; m++) begin
        e_kv[i][m] = 0; e_mk[i][m] = 0; e_kh[i][m] = 0; code_ev[i][m] = -1;
        e_col[i][m] = (1 << p_cols[i]) - 1;
      end
    end

    // Default instance: row 2 col 1 held 20, 2-cycle bounce, rows 1+3 chord, reset mid-hold.
    add_iv(0, 2, 1, 2, 22);
    single(0, 2, 1, 2, 22, idle, acc);
    t = idle + 2;
    add_iv(0, 0, 3, t, t + 2);
    single(0, 0, 3, t, t + 2, idle, acc);
    t = idle;
    add_iv(0, 1, 0, t, t + 6);
    add_iv(0, 3, 0, t, t + 6);
    multi(0, 0, t, t + 6, idle);
    t = idle;
    add_iv(0, 2, 1, t, t + 40);
    rst_x = t + 12;
    single(0, 2, 1, t, rst_x, idle, acc);
    code_ev[0][rst_x + 1] = 0;
    single(0, 2, 1, rst_x + 1, t + 40, idle, acc);
    plan_rand(0, idle + 3);

    // Auto-repeat instance: row 3 col 0 held 30.
    add_iv(1, 3, 0, 2, 32);
    single(1, 3, 0, 2, 32, idle, acc);
    plan_rand(1, idle + 3);

    // 2x8 instance: row 1 col 7, then a short tap that lets the walk wrap.
    add_iv(2, 1, 7, 2, 30);
    single(2, 1, 7, 2, 30, idle, acc);
    t = idle + 2;
    add_iv(2, 0, 4, t, t + 2);
    single(2, 0, 4, t, t + 2, idle, acc);
    plan_rand(2, idle + 1);

    for (int i = 0; i < 3; i++) begin
      cur = 0;
      for (int m = 0; m < NCYC; m++) begin
        if (code_ev[i][m] >= 0) cur = code_ev[i][m];
        e_code[i][m] = cur;
      end
    end

    repeat (3) @(negedge clk_div);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    for (int m = 0; m < NCYC; m++) begin
      @(negedge clk_div);
      cyc = m;
      chk("kv0",   32'(if0.key_valid), e_kv[0][m]);
      chk("mk0",   32'(if0.multi_key), e_mk[0][m]);
      chk("kh0",   32'(if0.key_held),  e_kh[0][m]);
      chk("code0", 32'(if0.key_code),  e_code[0][m]);
      chk("col0",  32'(if0.col),       e_col[0][m]);
      chk("kv1",   32'(if1.key_valid), e_kv[1][m]);
      chk("mk1",   32'(if1.multi_key), e_mk[1][m]);
      chk("kh1",   32'(if1.key_held),  e_kh[1][m]);
      chk("code1", 32'(if1.key_code),  e_code[1][m]);
      chk("col1",  32'(if1.col),       e_col[1][m]);
      chk("kv2",   32'(if2.key_valid), e_kv[2][m]);
      chk("mk2",   32'(if2.multi_key), e_mk[2][m]);
      chk("kh2",   32'(if2.key_held),  e_kh[2][m]);
      chk("code2", 32'(if2.key_code),  e_code[2][m]);
      chk("col2",  32'(if2.col),       e_col[2][m]);
      if0.sync_row = 4'(rows_of(0, m, int'(if0.col)));
      if1.sync_row = 4'(rows_of(1, m, int'(if1.col)));
      if2.sync_row = 2'(rows_of(2, m, int'(if2.col)));
      rst0 = (m == rst_x);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
